// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared encodings and helpers for the branch resolve unit
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_COND = 2'b01,
    OP_JAL  = 2'b10,
    OP_JALR = 2'b11
  } branch_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Index width of the BHT for a given (power-of-two) depth.
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch lookup, EX request and resolve result bundle
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic [1:0]      branch_op;
  logic [2:0]      func3;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] imm;
  logic            ex_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] link_data;
  logic            misalign_err;

  modport master (
    output if_pc, ex_valid, branch_op, func3, r1, r2, ex_pc, imm, ex_pred_taken,
    input  if_pred_taken, redirect_valid, redirect_pc, link_data, misalign_err
  );

  modport slave (
    input  if_pc, ex_valid, branch_op, func3, r1, r2, ex_pc, imm, ex_pred_taken,
    output if_pred_taken, redirect_valid, redirect_pc, link_data, misalign_err
  );
endinterface

// File: rtl/branch_resolve_unit_cond.sv
// rtl/branch_resolve_unit_cond.sv - combinational branch condition comparator
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [2:0]      func3,
  output logic            taken,
  output logic            legal
);

  // Evaluate the selected compare; unknown func3 codes report illegal and not-taken.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (func3)
      F3_BEQ:  taken = (r1 == r2);
      F3_BNE:  taken = (r1 != r2);
      F3_BLT:  taken = ($signed(r1) <  $signed(r2));
      F3_BGE:  taken = ($signed(r1) >= $signed(r2));
      F3_BLTU: taken = (r1 <  r2);
      F3_BGEU: taken = (r1 >= r2);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/jump resolution with BHT and profiling counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     mispred_cnt
);

  localparam int IDX_W = idx_w(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  logic            resolve;
  logic            is_cond;
  logic            is_jalr;
  logic            cond_taken;
  logic            cond_legal;
  logic            taken;
  logic            need_redirect;
  logic            misalign;
  logic            do_redirect;
  logic            bht_we;
  logic            count_branch;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .r1    (bus.r1),
    .r2    (bus.r2),
    .func3 (bus.func3),
    .taken (cond_taken),
    .legal (cond_legal)
  );

  assign rd_idx = bus.if_pc[IDX_W+1:2];
  assign wr_idx = bus.ex_pc[IDX_W+1:2];

  // Fetch sees the stored counter directly; a same-cycle update is not bypassed.
  assign bus.if_pred_taken = bht[rd_idx][1];

  // Decode the EX op into outcome, target and the side effects it triggers.
  always_comb begin
    resolve       = bus.ex_valid && (bus.branch_op != OP_NONE);
    is_cond       = (bus.branch_op == OP_COND);
    is_jalr       = (bus.branch_op == OP_JALR);
    jalr_sum      = bus.r1 + bus.imm;
    seq_pc        = bus.ex_pc + XLEN'(4);
    target        = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.ex_pc + bus.imm);
    // An illegal func3 resolves as not-taken, so a taken prediction still gets undone.
    taken         = is_cond ? (cond_taken && cond_legal) : 1'b1;
    // Fetch only predicts direction, so every jump needs a redirect to its target.
    need_redirect = is_cond ? (taken != bus.ex_pred_taken) : 1'b1;
    next_pc       = taken ? target : seq_pc;
    misalign      = resolve && taken && target[1];
    do_redirect   = resolve && need_redirect && !misalign;
    bht_we        = resolve && is_cond && cond_legal;
    count_branch  = resolve && !(is_cond && !cond_legal);
  end

  // Result registers: pulses clear every idle cycle, addresses hold until the next resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect_valid <= 1'b0;
      bus.misalign_err   <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.link_data      <= '0;
    end else begin
      bus.redirect_valid <= do_redirect;
      bus.misalign_err   <= misalign;
      if (resolve) begin
        bus.redirect_pc <= next_pc;
        bus.link_data   <= seq_pc;
      end
    end
  end

  // Two-bit saturating direction counters, trained only by legal conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= BHT_RESET;
      end
    end else if (bht_we) begin
      if (taken && (bht[wr_idx] != 2'b11)) begin
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else if (!taken && (bht[wr_idx] != 2'b00)) begin
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end

  // Profiling counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (count_branch && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (do_redirect && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX_W+2], jalr_sum[0]};

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator in the RISC-V execute stage of the WOS-filter processor.
- Resolves conditional branches, JAL and JALR in EX, computes the target and link address, and checks the resolved outcome against the fetch-time prediction.
- Owns a BHT of 2-bit saturating counters that fetch reads and EX updates.
- Keeps saturating branch and mispredict counters for filter-kernel profiling.

Parameters:
- XLEN, 32: operand, PC and target width.
- BHT_DEPTH, 16: number of BHT entries; power of two, at least 2.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC used for the BHT lookup
- if_pred_taken  out  1  combinational: MSB of BHT[if_pc[IDX+1:2]], where IDX=log2(BHT_DEPTH)
- ex_valid  in  1  EX holds a valid instruction this cycle
- branch_op  in  2  00 none, 01 conditional, 10 JAL, 11 JALR
- func3  in  3  condition select: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
- r1, r2  in  XLEN  source operands
- ex_pc  in  XLEN  PC of the EX instruction
- imm  in  XLEN  sign-extended immediate
- ex_pred_taken  in  1  prediction that travelled with the instruction
- redirect_valid  out  1  registered one-cycle pulse requesting a fetch redirect and a younger-stage flush
- redirect_pc  out  XLEN  registered redirect address
- link_data  out  XLEN  registered ex_pc+4, for rd writeback of JAL/JALR
- misalign_err  out  1  registered one-cycle pulse: taken target has bit 1 set
- branch_cnt, mispred_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs go to 0 and both counters go to 0.
  - Every BHT entry goes to 2'b01 (weakly not-taken).
  - Reset mid-operation drops any pending redirect; no partial update survives.
- Resolution happens only when ex_valid=1 and branch_op!=00. Otherwise, on the next edge, redirect_valid=0, misalign_err=0, and the BHT and counters hold.
- Condition: signed compares for BLT/BGE, unsigned for BLTU/BGEU, equality for BEQ/BNE.
- Invalid func3 (010, 011): treated as not-taken. No BHT update, branch_cnt does not count, and a redirect is raised only if ex_pred_taken=1 (redirect_pc=ex_pc+4).
- Target address (all sums are modulo 2^XLEN, so wrap-around is legal):
  - Conditional and JAL: ex_pc+imm.
  - JALR: (r1+imm) with bit 0 cleared.
- Taken: conditional uses the comparison result; JAL and JALR are always taken.
- Latency: 1 cycle. Registered outputs are valid on the edge after the EX cycle.
- Redirect rules:
  - Conditional: redirect when taken != ex_pred_taken. redirect_pc is the target if taken, otherwise ex_pc+4.
  - JAL and JALR: always redirect to the target, since fetch predicts direction only.
  - Misaligned taken target (bit 1 = 1): misalign_err=1 and redirect_valid=0.
- link_data updates on every resolved op and holds otherwise.
- BHT update (valid conditional with legal func3 only), index ex_pc[IDX+1:2]:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Same-cycle read and write of one index: if_pred_taken returns the pre-update value (no bypass).
- Counters:
  - branch_cnt increments on every resolved op except invalid func3.
  - mispred_cnt increments when redirect_valid is set.
  - Both saturate at all-ones, with no wrap.
- Back-to-back resolutions in consecutive cycles are supported. Each produces its own one-cycle pulse.

Decomposition:
- Shared package:
  - branch_op encodings.
  - func3 condition constants.
  - BHT counter reset value 2'b01.
  - Helper constant IDX_W = $clog2(BHT_DEPTH).
- One natural sub-module: branch_cond, a purely combinational XLEN-wide comparator (r1, r2, func3 -> taken, legal).
- BHT storage and counters stay in the top module.

Test Plan:
- Reset, then read if_pc=0x40: if_pred_taken=0. After clk, redirect_valid=0, branch_cnt=0, and every BHT entry reads 01.
- BLT with r1=0xFFFFFFFF, r2=1, ex_pc=0x100, imm=0x20, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x120, mispred_cnt=1. Same operands under BLTU -> not taken, no redirect.
- JALR with r1=0x203, imm=0x4, ex_pc=0x80 -> redirect_pc=0x206 gives misalign_err=1, redirect_valid=0, link_data=0x84. Repeat with r1=0x201 -> redirect_pc=0x204, redirect_valid=1.
- BHT saturation: four taken BEQ at ex_pc=0x10 -> entry 4 goes 01→10→11→11. Meanwhile if_pc=0x10 read in the cycle of the second update shows the pre-update value (MSB 0 on the first update, MSB 1 afterwards).
- Wrap-around: ex_pc=0xFFFFFFF8, imm=0x10, BNE taken -> redirect_pc=0x00000008. CNT_W=2 with five mispredicts -> mispred_cnt holds at 3.
- Assert rst_n low in the cycle after a mispredicting branch -> redirect_valid drops to 0 asynchronously, and the counters clear.
